seg7_count_display: RTL
=======================

Name: seg7_count_display

Overview:
Downstream consumer of the 16-bit event counter. It samples the counter value on request and converts it from binary to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes four digits onto a common-anode 7-segment display. Values above 9999 are flagged as overflow and shown as dashes.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (minimum 2); the bench uses 4.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  16  binary count from the upstream counter
sample_req  input  1  single-cycle request to latch and convert value
busy  output  1  conversion in progress; sample_req is ignored while high
ovf  output  1  displayed value exceeded 9999
an  output  4  digit anodes, active-low; an[0] = units digit
seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
dp  output  1  decimal point, active-low; held 1 (off)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous, active-low, and applies to every register.
- Reset values:
  - state=IDLE, busy=0, ovf=0.
  - Display digits all 0; scan index 0; prescaler 0.
  - an=4'b1110, seg=7'b1000000 (digit '0'), dp=1.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: when sample_req=1 at edge E0:
    - value is loaded into a 16-bit shift register.
    - The 20-bit BCD accumulator is cleared and the iteration counter is set to 0.
    - state->CONVERT, busy=1.
  - CONVERT: one iteration per cycle.
    - Each BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
    - After 16 iterations (edge E16), state->UPDATE.
  - UPDATE (edge E17):
    - The four low BCD nibbles are copied to the display digit registers.
    - ovf = (ten-thousands nibble != 0).
    - busy=0, state->IDLE.
- Latency and handshake:
  - busy is high for exactly 17 cycles.
  - New digits are visible after E17.
  - The earliest next accepted sample_req is at E18.
  - sample_req while busy=1 is dropped, with no queuing.
  - value only needs to be stable at E0.
- Display update: the old display persists unchanged throughout a conversion.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count the scan index increments mod 4 (0,1,2,3,0).
  - an is registered one-hot-low of the index; seg is registered at the same edge, so an and seg never mismatch.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Overflow: when ovf=1 every digit shows a dash, seg=0111111.
- Reset mid-operation:
  - Conversion is aborted and the display returns to '0' on all digits.
  - No partial result is ever displayed.

Optional Feature:
LEAD_ZERO_BLANK_EN:
- Defined:
  - Digits 3..1 are blanked (seg=1111111) when they and all higher digits are zero.
  - Digit 0 is never blanked.
  - Overflow dashes are never blanked.
  - The reset display is blank on digits 3..1 and '0' on digit 0.
- Undefined: leading zeros are shown as '0'.

Test Plan:
- Reset:
  - Assert rst_n=0 asynchronously between edges -> an=1110, seg=1000000, busy=0, ovf=0 immediately.
  - SCAN_DIV=4 free-run -> an cycles 1110,1101,1011,0111 every 4 clocks.
- Conversion of 1234:
  - value=16'd1234, 1-cycle sample_req -> busy high exactly 17 cycles, ovf=0.
  - Scan then shows seg 0011001 on an=1110, 0110000 on 1101, 0100100 on 1011, 1111001 on 0111.
- Overflow boundary:
  - value=9999 -> all digits 0010010... correction: all digits 0010000 ('9'), ovf=0.
  - Then value=10000 -> ovf=1, all digits 0111111.
  - Then value=65535 -> ovf=1, all digits 0111111.
- Dropped request:
  - After a 1234 request, pulse sample_req with value=5678 at E5 -> ignored.
  - Display is 1234; busy falls after E17.
  - A request at E18 with 5678 is accepted.
- Reset mid-conversion:
  - rst_n=0 at E8 of a 4321 conversion -> busy=0 and digits 0000.
  - After release, no update ever shows 4321 until re-requested.
- Leading-zero blanking (LEAD_ZERO_BLANK_EN defined):
  - value=7 -> digits 3..1 seg=1111111, digit 0 seg=1111000.
  - value=0 -> digit 0 seg=1000000.
  - Undefined macro, value=7 -> digits 3..1 seg=1000000.

Source files
------------

// File: rtl/seg7_count_display.sv
// Samples a 16-bit count, converts it to BCD with a serial double-dabble engine and
// scans four active-low 7-segment digits. Optional leading-zero blanking: LEAD_ZERO_BLANK_EN.
`timescale 1ns/1ps
module seg7_count_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        sample_req,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     shift_q, shift_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [3:0]      iter_q, iter_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [35:0]     dabble;
  logic            blank;

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    dabble   = {add3(bcd_q), shift_q};

    case (state_q)
      IDLE: begin
        if (sample_req) begin
          shift_d = value;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, shift_d} = {dabble[34:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = UPDATE;
      end
      UPDATE: begin
        // Display registers only change here, so a partial result is never shown.
        digits_d = bcd_q[15:0];
        ovf_d    = (bcd_q[19:16] != 4'd0);
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    idx_d   = (presc_q == PRESC_MAX) ? idx_q + 2'd1 : idx_q;
    an_d    = ~(4'b0001 << idx_d);
`ifdef LEAD_ZERO_BLANK_EN
    case (idx_d)
      2'd3:    blank = (digits_d[3] == 4'd0);
      2'd2:    blank = (digits_d[3] == 4'd0) && (digits_d[2] == 4'd0);
      2'd1:    blank = (digits_d[3] == 4'd0) && (digits_d[2] == 4'd0) && (digits_d[1] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    // seg is built from next-state digits and index so it lands on the same edge as an.
    if (ovf_d)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = decode(digits_d[idx_d]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      idx_q    <= '0;
      presc_q  <= '0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule
